// File: rtl/rps_pkg.sv
// Shared move codes, FSM state encoding, winner codes and the beats rule
// for the rock-paper-scissors referee.
package rps_pkg;

  typedef enum logic [2:0] {
    ROCK     = 3'd0,
    PAPER    = 3'd1,
    SCISSORS = 3'd2,
    SPOCK    = 3'd3,
    LIZARD   = 3'd4
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_JUDGE,
    ST_RESULT,
    ST_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_USER = 2'b01;
  localparam logic [1:0] WIN_COM  = 2'b10;

  // a beats b when (a - b) mod n is odd; zero difference is a tie
  function automatic logic rps_beats(input logic [2:0] a, input logic [2:0] b, input int n);
    int d;
    d = (int'(a) - int'(b) + n) % n;
    return d[0];
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: decides a/b/tie for two moves and flags
// codes outside the active move alphabet.
module rps_judge import rps_pkg::*; #(
  parameter int NUM_MOVES = 3
) (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       a_wins,
  output logic       b_wins,
  output logic       tie,
  output logic       a_illegal,
  output logic       b_illegal
);

  localparam logic [2:0] N_CODE = 3'(NUM_MOVES);

  always_comb begin
    a_illegal = (a >= N_CODE);
    b_illegal = (b >= N_CODE);
    a_wins    = rps_beats(a, b, NUM_MOVES) && !a_illegal && !b_illegal;
    b_wins    = rps_beats(b, a, NUM_MOVES) && !a_illegal && !b_illegal;
    tie       = (a == b) && !a_illegal && !b_illegal;
  end

endmodule

// File: rtl/rps_match_referee.sv
// Match referee: IDLE idle | WAIT collect both moves | JUDGE score round |
// RESULT strobe result | OVER match finished, hold scores.
module rps_match_referee import rps_pkg::*; #(
  parameter int NUM_MOVES  = 3,
  parameter int SCORE_W    = 8,
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 15,
  parameter int ROUND_W    = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               new_match,
  input  logic               user_valid,
  input  logic [2:0]         user_move,
  output logic               user_ready,
  input  logic               com_valid,
  input  logic [2:0]         com_move,
  output logic               com_ready,
  output logic               result_valid,
  output logic               uwin,
  output logic               cwin,
  output logic               draw,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] com_score,
  output logic [SCORE_W-1:0] draw_score,
  output logic [ROUND_W-1:0] round_count,
  output logic [2:0]         last_user,
  output logic [2:0]         last_com,
  output logic               bad_move,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);
  localparam logic [ROUND_W-1:0] ROUND_CAP = ROUND_W'(MAX_ROUNDS);

  state_t     state, state_nxt;
  logic       user_cap, com_cap;
  logic [2:0] user_mv, com_mv;
  logic [2:0] judge_a, judge_b;
  logic       a_wins, b_wins, tie, a_illegal, b_illegal;
  logic       user_take, com_take, user_bad, com_bad, over_hit;

  // Before capture the judge screens the offered move; afterwards it judges the held one.
  assign judge_a = user_cap ? user_mv : user_move;
  assign judge_b = com_cap  ? com_mv  : com_move;

  rps_judge #(.NUM_MOVES(NUM_MOVES)) u_judge (
    .a         (judge_a),
    .b         (judge_b),
    .a_wins    (a_wins),
    .b_wins    (b_wins),
    .tie       (tie),
    .a_illegal (a_illegal),
    .b_illegal (b_illegal)
  );

  assign user_take = user_valid && user_ready && !a_illegal;
  assign com_take  = com_valid  && com_ready  && !b_illegal;
  assign user_bad  = user_valid && user_ready && a_illegal;
  assign com_bad   = com_valid  && com_ready  && b_illegal;
  assign over_hit  = (user_score == TARGET) || (com_score == TARGET) || (round_count == ROUND_CAP);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_match) begin
      state_nxt = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:   if ((user_cap || user_take) && (com_cap || com_take)) state_nxt = ST_JUDGE;
        ST_JUDGE:  state_nxt = ST_RESULT;
        ST_RESULT: state_nxt = over_hit ? ST_OVER : ST_WAIT;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    user_ready   = (state == ST_WAIT) && !user_cap;
    com_ready    = (state == ST_WAIT) && !com_cap;
    result_valid = (state == ST_RESULT) && !new_match;
    match_over   = (state == ST_OVER);
    busy         = (state == ST_WAIT) || (state == ST_JUDGE) || (state == ST_RESULT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      user_cap     <= 1'b0;
      com_cap      <= 1'b0;
      user_mv      <= '0;
      com_mv       <= '0;
      uwin         <= 1'b0;
      cwin         <= 1'b0;
      draw         <= 1'b0;
      user_score   <= '0;
      com_score    <= '0;
      draw_score   <= '0;
      round_count  <= '0;
      last_user    <= '0;
      last_com     <= '0;
      bad_move     <= 1'b0;
      match_winner <= WIN_NONE;
    end else begin
      bad_move <= 1'b0;
      if (new_match) begin
        user_cap     <= 1'b0;
        com_cap      <= 1'b0;
        uwin         <= 1'b0;
        cwin         <= 1'b0;
        draw         <= 1'b0;
        user_score   <= '0;
        com_score    <= '0;
        draw_score   <= '0;
        round_count  <= '0;
        match_winner <= WIN_NONE;
      end else begin
        case (state)
          ST_WAIT: begin
            if (user_take) begin
              user_cap <= 1'b1;
              user_mv  <= user_move;
            end
            if (com_take) begin
              com_cap <= 1'b1;
              com_mv  <= com_move;
            end
            bad_move <= user_bad || com_bad;
          end
          ST_JUDGE: begin
            uwin        <= a_wins;
            cwin        <= b_wins;
            draw        <= tie;
            if (a_wins) user_score <= user_score + 1'b1;
            if (b_wins) com_score  <= com_score + 1'b1;
            if (tie && (draw_score != '1)) draw_score <= draw_score + 1'b1;
            round_count <= round_count + 1'b1;
            last_user   <= user_mv;
            last_com    <= com_mv;
          end
          ST_RESULT: begin
            user_cap <= 1'b0;
            com_cap  <= 1'b0;
            if (over_hit) begin
              if (user_score > com_score)      match_winner <= WIN_USER;
              else if (com_score > user_score) match_winner <= WIN_COM;
              else                             match_winner <= WIN_NONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_referee.sv
// Self-checking bench: a 3-move referee (target 3, cap 4 rounds) and a 5-move
// referee, checked against a game-rules model built from the beats list.
module tb_rps_match_referee;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic       reset = 1'b0;
  logic       new_match [2] = '{1'b0, 1'b0};
  logic       user_valid [2] = '{1'b0, 1'b0};
  logic       com_valid [2] = '{1'b0, 1'b0};
  logic [2:0] user_move [2] = '{3'd0, 3'd0};
  logic [2:0] com_move [2] = '{3'd0, 3'd0};
  logic       user_ready [2], com_ready [2], result_valid [2];
  logic       uwin [2], cwin [2], draw [2], bad_move [2], match_over [2], busy [2];
  logic [7:0] user_score [2], com_score [2], draw_score [2], round_count [2];
  logic [2:0] last_user [2], last_com [2];
  logic [1:0] match_winner [2];

  rps_match_referee #(.NUM_MOVES(3), .SCORE_W(8), .WIN_TARGET(3), .MAX_ROUNDS(4), .ROUND_W(8)) d3 (
    .CLOCK_50(CLOCK_50), .reset(reset), .new_match(new_match[0]),
    .user_valid(user_valid[0]), .user_move(user_move[0]), .user_ready(user_ready[0]),
    .com_valid(com_valid[0]), .com_move(com_move[0]), .com_ready(com_ready[0]),
    .result_valid(result_valid[0]), .uwin(uwin[0]), .cwin(cwin[0]), .draw(draw[0]),
    .user_score(user_score[0]), .com_score(com_score[0]), .draw_score(draw_score[0]),
    .round_count(round_count[0]), .last_user(last_user[0]), .last_com(last_com[0]),
    .bad_move(bad_move[0]), .match_over(match_over[0]), .match_winner(match_winner[0]),
    .busy(busy[0])
  );

  rps_match_referee #(.NUM_MOVES(5), .SCORE_W(8), .WIN_TARGET(255), .MAX_ROUNDS(30), .ROUND_W(8)) d5 (
    .CLOCK_50(CLOCK_50), .reset(reset), .new_match(new_match[1]),
    .user_valid(user_valid[1]), .user_move(user_move[1]), .user_ready(user_ready[1]),
    .com_valid(com_valid[1]), .com_move(com_move[1]), .com_ready(com_ready[1]),
    .result_valid(result_valid[1]), .uwin(uwin[1]), .cwin(cwin[1]), .draw(draw[1]),
    .user_score(user_score[1]), .com_score(com_score[1]), .draw_score(draw_score[1]),
    .round_count(round_count[1]), .last_user(last_user[1]), .last_com(last_com[1]),
    .bad_move(bad_move[1]), .match_over(match_over[1]), .match_winner(match_winner[1]),
    .busy(busy[1])
  );

  int checks = 0;
  int failures = 0;

  // Game rules as a list of (winner, loser) pairs: rock crushes scissors and lizard,
  // paper covers rock and disproves spock, scissors cut paper and decapitate lizard,
  // spock smashes scissors and vaporises rock, lizard eats paper and poisons spock.
  int win_pairs [10][2] = '{'{0,2}, '{0,4}, '{1,0}, '{1,3}, '{2,1},
                            '{2,4}, '{3,2}, '{3,0}, '{4,1}, '{4,3}};
  bit beats [5][5];

  int m_us [2], m_cs [2], m_ds [2], m_rnd [2];
  int p_tgt [2] = '{3, 255};
  int p_max [2] = '{4, 30};

  typedef struct {
    int u;
    int c;
    int ud;
    int cd;
    int exp_r;
  } vec_t;

  vec_t tab [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int outcome(input int a, input int b);
    if (beats[a][b]) return 1;
    if (beats[b][a]) return 2;
    return 0;
  endfunction

  function automatic bit model_over(input int k);
    return (m_us[k] == p_tgt[k]) || (m_cs[k] == p_tgt[k]) || (m_rnd[k] == p_max[k]);
  endfunction

  task automatic start_match(input int k);
    @(negedge CLOCK_50);
    new_match[k] = 1'b1;
    @(negedge CLOCK_50);
    new_match[k] = 1'b0;
    m_us[k] = 0; m_cs[k] = 0; m_ds[k] = 0; m_rnd[k] = 0;
    check("new_match_busy", busy[k], 1);
    check("new_match_scores", {user_score[k], com_score[k], draw_score[k], round_count[k]}, 0);
    check("new_match_over", match_over[k], 0);
    check("new_match_winner", match_winner[k], 0);
    check("new_match_ready", {user_ready[k], com_ready[k]}, 2'b11);
  endtask

  task automatic play(input int k, input int um, input int cm, input int ud, input int cd, input int exp_r);
    bit u_done = 1'b0, c_done = 1'b0, uhs, chs, exp_over;
    int cyc = 0;
    logic [1:0] exp_w;
    while (!(u_done && c_done) && cyc < 64) begin
      @(negedge CLOCK_50);
      if (u_done && !c_done) check("user_ready_drops", user_ready[k], 0);
      if (c_done && !u_done) check("com_ready_drops", com_ready[k], 0);
      user_valid[k] = !u_done && (cyc >= ud);
      user_move[k]  = 3'(um);
      com_valid[k]  = !c_done && (cyc >= cd);
      com_move[k]   = 3'(cm);
      #1;
      uhs = user_valid[k] && user_ready[k];
      chs = com_valid[k] && com_ready[k];
      @(posedge CLOCK_50);
      u_done = u_done | uhs;
      c_done = c_done | chs;
      cyc++;
    end
    check("capture_in_budget", {u_done, c_done}, 2'b11);
    @(negedge CLOCK_50);
    user_valid[k] = 1'b0;
    com_valid[k]  = 1'b0;
    check("result_not_early", result_valid[k], 0);
    @(negedge CLOCK_50);
    check("result_latency", result_valid[k], 1);
    if (exp_r == 1) m_us[k]++;
    else if (exp_r == 2) m_cs[k]++;
    else if (m_ds[k] < 255) m_ds[k]++;
    m_rnd[k]++;
    check("outcome_flags", {uwin[k], cwin[k], draw[k]}, {exp_r == 1, exp_r == 2, exp_r == 0});
    check("user_score", user_score[k], m_us[k]);
    check("com_score", com_score[k], m_cs[k]);
    check("draw_score", draw_score[k], m_ds[k]);
    check("round_count", round_count[k], m_rnd[k]);
    check("last_moves", {last_user[k], last_com[k]}, {3'(um), 3'(cm)});
    @(negedge CLOCK_50);
    check("result_one_cycle", result_valid[k], 0);
    exp_over = model_over(k);
    check("match_over", match_over[k], exp_over);
    if (exp_over) begin
      exp_w = (m_us[k] > m_cs[k]) ? 2'b01 : (m_cs[k] > m_us[k]) ? 2'b10 : 2'b00;
      check("match_winner", match_winner[k], exp_w);
      check("over_readies", {user_ready[k], com_ready[k], busy[k]}, 0);
    end else begin
      check("next_round_ready", {user_ready[k], com_ready[k]}, 2'b11);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 10; i++) beats[win_pairs[i][0]][win_pairs[i][1]] = 1'b1;
    tab = '{'{1, 0, 0, 0, 1}, '{0, 1, 0, 0, 2}, '{2, 1, 0, 0, 1}, '{1, 2, 0, 0, 2},
            '{0, 2, 0, 0, 1}, '{2, 0, 0, 0, 2}, '{0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0},
            '{2, 2, 0, 0, 0}, '{2, 1, 0, 3, 1}, '{0, 2, 4, 0, 1}};

    // reset state
    repeat (3) @(negedge CLOCK_50);
    check("reset_scores", {user_score[0], com_score[0], draw_score[0], round_count[0]}, 0);
    check("reset_flags", {uwin[0], cwin[0], draw[0], bad_move[0], match_over[0], busy[0]}, 0);
    check("reset_ready", {user_ready[0], com_ready[0], result_valid[0], match_winner[0]}, 0);
    check("reset_d5", {busy[1], user_ready[1], user_score[1], round_count[1]}, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("idle_stays", {busy[0], user_ready[0]}, 0);

    // 3-move table, each vector in a fresh match
    for (int i = 0; i < 11; i++) begin
      start_match(0);
      play(0, tab[i].u, tab[i].c, tab[i].ud, tab[i].cd, tab[i].exp_r);
    end

    // illegal user code, then illegal computer code, then a legal round
    start_match(0);
    @(negedge CLOCK_50);
    user_valid[0] = 1'b1; user_move[0] = 3'd4;
    @(negedge CLOCK_50);
    user_valid[0] = 1'b0;
    check("bad_move_user", bad_move[0], 1);
    check("user_ready_after_bad", user_ready[0], 1);
    com_valid[0] = 1'b1; com_move[0] = 3'd3;
    @(negedge CLOCK_50);
    com_valid[0] = 1'b0;
    check("bad_move_com", bad_move[0], 1);
    check("com_ready_after_bad", com_ready[0], 1);
    @(negedge CLOCK_50);
    check("bad_move_one_cycle", bad_move[0], 0);
    play(0, 2, 1, 0, 0, 1);

    // new_match mid-round aborts the captured user move
    start_match(0);
    @(negedge CLOCK_50);
    user_valid[0] = 1'b1; user_move[0] = 3'd1;
    @(negedge CLOCK_50);
    user_valid[0] = 1'b0;
    check("abort_user_captured", user_ready[0], 0);
    com_valid[0] = 1'b1; com_move[0] = 3'd0; new_match[0] = 1'b1;
    @(negedge CLOCK_50);
    com_valid[0] = 1'b0; new_match[0] = 1'b0;
    check("abort_ready_restored", {user_ready[0], com_ready[0]}, 2'b11);
    @(negedge CLOCK_50);
    check("abort_no_result", result_valid[0], 0);
    @(negedge CLOCK_50);
    check("abort_no_result2", {result_valid[0], round_count[0]}, 0);
    m_us[0] = 0; m_cs[0] = 0; m_ds[0] = 0; m_rnd[0] = 0;

    // computer wins three straight, then a new match clears it
    start_match(0);
    for (int i = 0; i < 3; i++) play(0, 0, 1, 0, 0, 2);
    @(negedge CLOCK_50);
    check("over_holds_score", {com_score[0], match_over[0]}, {8'd3, 1'b1});
    start_match(0);

    // four draws hit the round cap
    for (int i = 0; i < 4; i++) play(0, i % 3, i % 3, i % 2, 0, 0);
    check("cap_draw_score", draw_score[0], 4);

    // reset mid-match with user_score = 2, new_match ignored in that cycle
    start_match(0);
    play(0, 1, 0, 0, 0, 1);
    play(0, 1, 0, 1, 0, 1);
    @(negedge CLOCK_50);
    reset = 1'b0; new_match[0] = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b1; new_match[0] = 1'b0;
    check("midreset_scores", {user_score[0], com_score[0], draw_score[0], round_count[0]}, 0);
    check("midreset_flags", {uwin[0], cwin[0], draw[0], busy[0], match_over[0], match_winner[0]}, 0);
    check("midreset_hist", {last_user[0], last_com[0], user_ready[0], com_ready[0]}, 0);
    @(negedge CLOCK_50);
    check("midreset_idle", busy[0], 0);

    // 5-move sweep of all 25 pairs in one long match
    start_match(1);
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++)
        play(1, a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), outcome(a, b));

    // random 3-move matches with random handshake timing
    for (int i = 0; i < 40; i++) begin
      int um, cm;
      if (i == 0 || model_over(0)) start_match(0);
      um = int'($urandom_range(0, 2));
      cm = int'($urandom_range(0, 2));
      play(0, um, cm, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), outcome(um, cm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
